iir_ch_scheduler: RTL and testbench
===================================

// Module: iir_ch_scheduler
// PURPOSE
// Time-multiplexes one first-order IIR section datapath among NCH sample requesters.
// - Holds the per-channel filter state (y[n-1]), arbitrates round-robin and drives the datapath with (x, state).
// - Writes the datapath result back as the new channel state and returns it with its channel index.
// - Sits between the sample sources and the shared iir section; samples are Q1.10 signed.
// PARAMETERS
// W        11   sample/state width, signed Q1.(W-1)
// NCH      4    number of requesting channels (>=2)
// TIMEOUT  16   max cycles in WAIT for dp_done before abort
// PORTS
// clk        in   1        clock, all logic on rising edge
// rst        in   1        synchronous active-high reset
// req_i      in   NCH      per-channel sample request, held until ack
// x_i        in   NCH*W    packed samples, channel c at [c*W +: W], stable while req_i[c]
// clear_i    in   NCH      per-channel state clear pulse
// ack_o      out  NCH      one-hot, 1-cycle: channel's x sampled
// dp_start_o out  1        1-cycle strobe to datapath
// dp_x_o     out  W        sample to datapath
// dp_s_o     out  W        channel state y[n-1] to datapath
// dp_y_i     in   W        datapath result, valid with dp_done_i
// dp_done_i  in   1        datapath result strobe
// y_o        out  W        filtered output, held between valids
// y_ch_o     out  $clog2(NCH)  channel of y_o
// y_valid_o  out  1        1-cycle output strobe
// err_o      out  1        sticky timeout flag
// BEHAVIOUR
// - Reset: FSM=IDLE, rr pointer=0, all states=0, all outputs 0 (incl. y_o, y_ch_o, err_o); cleared only by rst.
// - FSM (Moore; outputs decoded from registered state):
//   - IDLE: if any req_i: grant g, latch x_i[g] and state[g]; go to ISSUE. Else stay.
//   - ISSUE: ack_o[g]=1, dp_start_o=1, dp_x_o/dp_s_o = latched values; go to WAIT, wait counter=0.
//   - WAIT: on dp_done_i: capture dp_y_i, go to WB.
//     - Else counter++; at counter==TIMEOUT-1: set err_o, go to IDLE.
//     - No write-back and no y_valid_o on timeout.
//   - WB: y_valid_o=1, y_o=captured value, y_ch_o=g; state[g] <= captured value; go to IDLE.
// - Arbitration: grant = first c with req_i[c] scanning from pointer upward mod NCH; pointer <= g+1 mod NCH on grant.
// - Timing with a datapath asserting dp_done_i the cycle after dp_start_o:
//   - req seen at edge 0 -> ack/start high cycle 1, WAIT cycle 2, WB (y_valid_o) cycle 3, IDLE cycle 4.
//   - Next grant at edge 4; period 4 cycles/sample.
// - dp_done_i outside WAIT is ignored.
// - dp_x_o, dp_s_o hold their last values outside ISSUE.
// - Data passes unmodified: no rounding or saturation in this block, sign preserved.
// - clear_i[c]: state[c] <= 0 next edge.
//   - Same edge as WB for c: clear wins, state stays 0; y_valid_o/y_o still emitted.
//   - clear during ISSUE/WAIT for c: dp_s_o already latched; result still output, write-back still occurs.
// - rst mid-operation (any state) aborts: next cycle IDLE with reset values, in-flight sample discarded.
// TESTING
// 1. Impulse: stub datapath y=x+(s>>>1). ch0 x=01111111111 once then 0 x5:
//    y_o = 0x3FF,0x1FF,0x0FF,0x07F,0x03F,0x01F; y_ch_o=0.
// 2. After reset, req_i=4'b1111 held: ack_o order 0,1,2,3 at 4-cycle spacing, then 0 again.
// 3. req_i[1] held, req_i[2] held: grants alternate 1,2,1,2; neither starves.
// 4. State settled, then clear_i[0] pulsed on ch0's WB cycle: y_valid_o still 1.
//    Next ch0 x=0x100 -> y_o=0x100.
// 5. Stub never asserts dp_done_i: err_o=1 exactly TIMEOUT cycles into WAIT; FSM returns to IDLE.
//    No y_valid_o; state unchanged.
// 6. rst pulsed during WAIT, then dp_done_i arrives late:
//    all outputs 0, states 0, no y_valid_o, next request served normally.

Source files
------------

// File: rtl/iir_ch_scheduler.sv
// iir_ch_scheduler
// Shares one first-order IIR section among NCH requesting channels. Keeps each
// channel's y[n-1], picks requesters round-robin, hands (x, state) to the
// datapath, and writes the datapath result back as the channel's new state.
module iir_ch_scheduler #(
  parameter int W       = 11,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req_i,
  input  logic [NCH*W-1:0]         x_i,
  input  logic [NCH-1:0]           clear_i,
  output logic [NCH-1:0]           ack_o,
  output logic                     dp_start_o,
  output logic [W-1:0]             dp_x_o,
  output logic [W-1:0]             dp_s_o,
  input  logic [W-1:0]             dp_y_i,
  input  logic                     dp_done_i,
  output logic [W-1:0]             y_o,
  output logic [$clog2(NCH)-1:0]   y_ch_o,
  output logic                     y_valid_o,
  output logic                     err_o
);

  localparam int CHW  = $clog2(NCH);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WB
  } fsmState_t;

  fsmState_t         fsm_q;
  logic [CHW-1:0]    rrPtr_q;
  logic [CHW-1:0]    grant_q;
  logic [CNTW-1:0]   cnt_q;
  logic [NCH-1:0]    ack_q;
  logic              start_q;
  logic [W-1:0]      dpX_q;
  logic [W-1:0]      dpS_q;
  logic [W-1:0]      y_q;
  logic [CHW-1:0]    yCh_q;
  logic              yValid_q;
  logic              err_q;
  logic [W-1:0]      chState_q [NCH];

  logic              anyReq_d;
  logic [CHW-1:0]    grant_d;
  logic [CHW-1:0]    scanIdx;

  // Offset a channel index upward, wrapping at NCH (NCH need not be a power of two).
  function automatic logic [CHW-1:0] wrapIdx(input logic [CHW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return CHW'(s);
  endfunction

  // Round-robin pick: first requester at or above the pointer, wrapping around.
  always_comb begin
    anyReq_d = 1'b0;
    grant_d  = '0;
    scanIdx  = '0;
    for (int k = 0; k < NCH; k++) begin
      scanIdx = wrapIdx(rrPtr_q, k);
      if (!anyReq_d && req_i[scanIdx]) begin
        anyReq_d = 1'b1;
        grant_d  = scanIdx;
      end
    end
  end

  // Scheduler FSM; every output is a register so the datapath sees clean strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= ST_IDLE;
      rrPtr_q  <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      start_q  <= 1'b0;
      dpX_q    <= '0;
      dpS_q    <= '0;
      y_q      <= '0;
      yCh_q    <= '0;
      yValid_q <= 1'b0;
      err_q    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        chState_q[c] <= '0;
      end
    end else begin
      ack_q    <= '0;
      start_q  <= 1'b0;
      yValid_q <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (anyReq_d) begin
            grant_q <= grant_d;
            rrPtr_q <= wrapIdx(grant_d, 1);
            dpX_q   <= x_i[int'(grant_d)*W +: W];
            dpS_q   <= chState_q[grant_d];
            ack_q   <= {{(NCH-1){1'b0}}, 1'b1} << grant_d;
            start_q <= 1'b1;
            fsm_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          fsm_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dp_done_i) begin
            y_q      <= dp_y_i;
            yCh_q    <= grant_q;
            yValid_q <= 1'b1;
            fsm_q    <= ST_WB;
          end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            fsm_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WB: begin
          chState_q[grant_q] <= y_q;
          fsm_q              <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
      // A clear landing on the write-back edge overrides the write-back.
      for (int c = 0; c < NCH; c++) begin
        if (clear_i[c]) chState_q[c] <= '0;
      end
    end
  end

  assign ack_o      = ack_q;
  assign dp_start_o = start_q;
  assign dp_x_o     = dpX_q;
  assign dp_s_o     = dpS_q;
  assign y_o        = y_q;
  assign y_ch_o     = yCh_q;
  assign y_valid_o  = yValid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_iir_ch_scheduler.sv
// Directed bench for iir_ch_scheduler with a stub datapath computing y = x + (s >>> 1).
module tb_iir_ch_scheduler;

  localparam int W       = 11;
  localparam int NCH     = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_i;
  logic [NCH*W-1:0]  x_i;
  logic [NCH-1:0]    clear_i;
  logic [NCH-1:0]    ack_o;
  logic              dp_start_o;
  logic [W-1:0]      dp_x_o;
  logic [W-1:0]      dp_s_o;
  logic [W-1:0]      dp_y_i;
  logic              dp_done_i;
  logic [W-1:0]      y_o;
  logic [1:0]        y_ch_o;
  logic              y_valid_o;
  logic              err_o;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  int validSeen   = 0;

  logic              stubOn     = 1'b1;
  logic              stubDone   = 1'b0;
  logic              startSeen  = 1'b0;
  logic [W-1:0]      stubY      = '0;
  logic [W-1:0]      pendY      = '0;
  logic              manualDone = 1'b0;
  logic [W-1:0]      manualY    = '0;

  iir_ch_scheduler #(.W(W), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .x_i        (x_i),
    .clear_i    (clear_i),
    .ack_o      (ack_o),
    .dp_start_o (dp_start_o),
    .dp_x_o     (dp_x_o),
    .dp_s_o     (dp_s_o),
    .dp_y_i     (dp_y_i),
    .dp_done_i  (dp_done_i),
    .y_o        (y_o),
    .y_ch_o     (y_ch_o),
    .y_valid_o  (y_valid_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  assign dp_done_i = stubDone | manualDone;
  assign dp_y_i    = manualDone ? manualY : stubY;

  // Stub datapath: answers one cycle after seeing dp_start_o.
  initial begin
    logic signed [W-1:0] sx;
    logic signed [W-1:0] ss;
    forever begin
      @(posedge clk);
      #1;
      stubDone  = stubOn && startSeen;
      stubY     = pendY;
      startSeen = dp_start_o;
      if (dp_start_o) begin
        sx    = dp_x_o;
        ss    = dp_s_o;
        pendY = sx + (ss >>> 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycleCount++;
    if (y_valid_o) validSeen++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] req, input logic [NCH*W-1:0] xs,
                               input logic [NCH-1:0] clr);
    req_i   = req;
    x_i     = xs;
    clear_i = clr;
  endtask

  task automatic doReset();
    applyStimulus('0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitAck(input int expCh, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (ack_o == '0 && n < 20);
    checkOutput(tag, 32'(ack_o), 32'(1 << expCh));
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!y_valid_o && n < TIMEOUT + 8);
    checkOutput(tag, 32'(y_valid_o), 32'd1);
  endtask

  task automatic serveOne(input int ch, input logic [W-1:0] x, input logic [W-1:0] expY,
                          input string tag);
    logic [NCH*W-1:0] xs;
    xs = '0;
    xs[ch*W +: W] = x;
    applyStimulus(NCH'(1 << ch), xs, '0);
    waitAck(ch, {tag, " ack"});
    checkOutput({tag, " dp_x"}, 32'(dp_x_o), 32'(x));
    req_i = '0;
    waitValid({tag, " valid"});
    checkOutput({tag, " y"}, 32'(y_o), 32'(expY));
    checkOutput({tag, " ych"}, 32'(y_ch_o), 32'(ch));
  endtask

  initial begin
    int lastAck;
    int v0;
    int expSeq [4];

    rst = 1'b1;
    applyStimulus('0, '0, '0);
    doReset();

    // Reset state
    checkOutput("rst ack", 32'(ack_o), 32'd0);
    checkOutput("rst start", 32'(dp_start_o), 32'd0);
    checkOutput("rst y", 32'(y_o), 32'd0);
    checkOutput("rst ych", 32'(y_ch_o), 32'd0);
    checkOutput("rst valid", 32'(y_valid_o), 32'd0);
    checkOutput("rst err", 32'(err_o), 32'd0);

    // 1. Impulse response on ch0, then a negative sample on ch3
    serveOne(0, 11'h3FF, 11'h3FF, "imp0");
    serveOne(0, 11'h000, 11'h1FF, "imp1");
    serveOne(0, 11'h000, 11'h0FF, "imp2");
    serveOne(0, 11'h000, 11'h07F, "imp3");
    serveOne(0, 11'h000, 11'h03F, "imp4");
    serveOne(0, 11'h000, 11'h01F, "imp5");
    serveOne(3, 11'h600, 11'h600, "neg0");
    serveOne(3, 11'h000, 11'h700, "neg1");

    // 2. All channels requesting: 0,1,2,3,0 at 4-cycle spacing
    doReset();
    applyStimulus(4'b1111, {11'h004, 11'h003, 11'h002, 11'h001}, '0);
    lastAck = 0;
    for (int i = 0; i < 5; i++) begin
      waitAck(i % 4, "rr4 order");
      if (i > 0) checkOutput("rr4 spacing", 32'(cycleCount - lastAck), 32'd4);
      lastAck = cycleCount;
    end
    req_i = '0;

    // 3. Channels 1 and 2 alternate
    doReset();
    applyStimulus(4'b0110, {11'h000, 11'h020, 11'h010, 11'h000}, '0);
    expSeq = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++) begin
      waitAck(expSeq[i], "rr2 order");
    end
    req_i = '0;

    // 4. Clear on ch0's write-back cycle wins over the write-back
    doReset();
    serveOne(0, 11'h100, 11'h100, "clr prep");
    applyStimulus(4'b0001, {33'd0, 11'h080}, '0);
    waitAck(0, "clr ack");
    req_i = '0;
    waitValid("clr wb valid");
    checkOutput("clr wb y", 32'(y_o), 32'h100);
    clear_i = 4'b0001;
    tick();
    clear_i = '0;
    serveOne(0, 11'h100, 11'h100, "clr after");

    // 5. Datapath never answers: timeout after TIMEOUT cycles in WAIT
    doReset();
    serveOne(2, 11'h100, 11'h100, "to prep");
    stubOn = 1'b0;
    applyStimulus(4'b0100, {11'h000, 11'h200, 22'd0}, '0);
    waitAck(2, "to ack");
    req_i = '0;
    v0 = validSeen;
    repeat (TIMEOUT) tick();
    checkOutput("to err early", 32'(err_o), 32'd0);
    tick();
    checkOutput("to err set", 32'(err_o), 32'd1);
    checkOutput("to no valid", 32'(validSeen), 32'(v0));
    stubOn = 1'b1;
    serveOne(2, 11'h000, 11'h080, "to state kept");
    checkOutput("to err sticky", 32'(err_o), 32'd1);

    // 6. Reset during WAIT, late dp_done ignored, then normal service
    doReset();
    serveOne(1, 11'h100, 11'h100, "rw prep");
    stubOn = 1'b0;
    applyStimulus(4'b0010, {22'd0, 11'h040, 11'h000}, '0);
    waitAck(1, "rw ack");
    req_i = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v0 = validSeen;
    checkOutput("rw y", 32'(y_o), 32'd0);
    checkOutput("rw ych", 32'(y_ch_o), 32'd0);
    checkOutput("rw dp_x", 32'(dp_x_o), 32'd0);
    checkOutput("rw dp_s", 32'(dp_s_o), 32'd0);
    manualY    = 11'h155;
    manualDone = 1'b1;
    tick();
    tick();
    manualDone = 1'b0;
    checkOutput("rw late done valid", 32'(validSeen), 32'(v0));
    checkOutput("rw late done y", 32'(y_o), 32'd0);
    checkOutput("rw err", 32'(err_o), 32'd0);
    stubOn = 1'b1;
    serveOne(1, 11'h100, 11'h100, "rw after");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
